// File: rtl/frame_scan_scheduler.sv
// frame_scan_scheduler
// Streams one full-screen frame of pixels from the sprite ROM into the LCD
// controller's pixel input. Each source pixel is replicated SCALE x SCALE
// (nearest-neighbour upscale). The block issues ROM reads, absorbs the
// one-cycle ROM latency and presents pixels on a valid/ready handshake.
// Scene selection is latched at frame start; redraw requests and scene
// changes seen mid-frame collapse into a single pending redraw.
//
// Ports:
//   clk_out      in   block clock
//   rst          in   synchronous, active-low reset
//   scene_sel    in   requested image index
//   frame_req    in   single-cycle redraw request
//   rom_en       out  ROM read strobe
//   rom_addr     out  ROM read address
//   rom_data     in   ROM data, valid the cycle after rom_en
//   pix_data     out  pixel presented to the controller
//   pix_valid    out  pix_data is valid
//   pix_ready    in   controller accepts pix_data this cycle
//   frame_busy   out  high from frame start until frame_done
//   frame_done   out  one-cycle pulse after the last pixel transfers
//   active_scene out  scene latched for the current or last frame
module frame_scan_scheduler #(
    parameter int unsigned SRC_W      = 80,
    parameter int unsigned SRC_H      = 80,
    parameter int unsigned SCALE      = 3,
    parameter int unsigned PIXEL_SIZE = 16,
    parameter int unsigned NUM_SCENES = 5,
    parameter int unsigned ADDR_W     = 15,
    parameter logic [PIXEL_SIZE-1:0] FILL_COLOR = 16'h001F
) (
    input  logic                  clk_out,
    input  logic                  rst,
    input  logic [2:0]            scene_sel,
    input  logic                  frame_req,
    output logic                  rom_en,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [PIXEL_SIZE-1:0] rom_data,
    output logic [PIXEL_SIZE-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  frame_busy,
    output logic                  frame_done,
    output logic [2:0]            active_scene
);

    localparam int unsigned SUB_W     = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int unsigned SX_W      = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int unsigned SY_W      = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int unsigned FRAME_PIX = SRC_W * SRC_H;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_PRESENT,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]       rom_addr_q, rom_addr_d;
    logic [PIXEL_SIZE-1:0]   pix_data_q, pix_data_d;
    logic                    pix_valid_q, pix_valid_d;
    logic                    frame_busy_q, frame_busy_d;
    logic                    frame_done_q, frame_done_d;
    logic [2:0]              active_scene_q, active_scene_d;
    logic                    pending_q, pending_d;
    logic [SUB_W-1:0]        sub_x_q, sub_x_d;
    logic [SUB_W-1:0]        sub_y_q, sub_y_d;
    logic [SX_W-1:0]         src_x_q, src_x_d;
    logic [SY_W-1:0]         src_y_q, src_y_d;
    logic [ADDR_W-1:0]       row_base_q, row_base_d;

    logic                    transfer_c;
    logic                    last_sub_x_c;
    logic                    last_sub_y_c;
    logic                    last_src_x_c;
    logic                    last_src_y_c;
    logic                    start_c;
    logic                    cur_scene_ok_c;
    logic                    new_scene_ok_c;
    logic [ADDR_W-1:0]       new_scene_base_c;

    // Handshake, counter-wrap and scene-validity decodes
    always_comb begin
        transfer_c     = pix_valid_q && pix_ready;
        last_sub_x_c   = (sub_x_q == SUB_W'(SCALE - 1));
        last_sub_y_c   = (sub_y_q == SUB_W'(SCALE - 1));
        last_src_x_c   = (src_x_q == SX_W'(SRC_W - 1));
        last_src_y_c   = (src_y_q == SY_W'(SRC_H - 1));
        start_c        = frame_req || pending_q || (scene_sel != active_scene_q);
        cur_scene_ok_c = (32'(active_scene_q) < NUM_SCENES);
        new_scene_ok_c = (32'(scene_sel) < NUM_SCENES);
        // Constant-coefficient product, only consumed once per frame start
        new_scene_base_c = ADDR_W'(32'(scene_sel) * FRAME_PIX);
    end

    // Next-state and output logic
    always_comb begin
        state_d        = state_q;
        rom_en_d       = 1'b0;
        rom_addr_d     = rom_addr_q;
        pix_data_d     = pix_data_q;
        pix_valid_d    = pix_valid_q;
        frame_busy_d   = frame_busy_q;
        frame_done_d   = 1'b0;
        active_scene_d = active_scene_q;
        sub_x_d        = sub_x_q;
        sub_y_d        = sub_y_q;
        src_x_d        = src_x_q;
        src_y_d        = src_y_q;
        row_base_d     = row_base_q;

        // Any request seen while a frame is in flight becomes one pending redraw
        pending_d = pending_q ||
                    ((state_q != ST_IDLE) &&
                     (frame_req || (scene_sel != active_scene_q)));

        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    active_scene_d = scene_sel;
                    sub_x_d        = '0;
                    sub_y_d        = '0;
                    src_x_d        = '0;
                    src_y_d        = '0;
                    row_base_d     = new_scene_base_c;
                    pending_d      = 1'b0;
                    frame_busy_d   = 1'b1;
                    // Read strobe is registered so it is visible during FETCH
                    rom_en_d       = new_scene_ok_c;
                    rom_addr_d     = new_scene_base_c;
                    state_d        = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (cur_scene_ok_c) begin
                    state_d = ST_WAIT;
                end else begin
                    pix_data_d  = FILL_COLOR;
                    pix_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end
            end

            ST_WAIT: begin
                pix_data_d  = rom_data;
                pix_valid_d = 1'b1;
                state_d     = ST_PRESENT;
            end

            ST_PRESENT: begin
                if (transfer_c) begin
                    if (last_sub_x_c && last_sub_y_c && last_src_x_c && last_src_y_c) begin
                        pix_valid_d  = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = ST_DONE;
                    end else if (!last_sub_x_c) begin
                        // Horizontal replication: same pixel, no ROM access
                        sub_x_d = sub_x_q + 1'b1;
                    end else begin
                        sub_x_d     = '0;
                        pix_valid_d = 1'b0;
                        if (!last_src_x_c) begin
                            src_x_d = src_x_q + 1'b1;
                        end else begin
                            src_x_d = '0;
                            if (!last_sub_y_c) begin
                                // Vertical replication: re-read the same source row
                                sub_y_d = sub_y_q + 1'b1;
                            end else begin
                                sub_y_d    = '0;
                                src_y_d    = src_y_q + 1'b1;
                                row_base_d = row_base_q + ADDR_W'(SRC_W);
                            end
                        end
                        rom_en_d   = cur_scene_ok_c;
                        rom_addr_d = row_base_d + ADDR_W'(src_x_d);
                        state_d    = ST_FETCH;
                    end
                end
            end

            ST_DONE: begin
                frame_busy_d = 1'b0;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk_out) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            rom_en_q       <= 1'b0;
            rom_addr_q     <= '0;
            pix_data_q     <= '0;
            pix_valid_q    <= 1'b0;
            frame_busy_q   <= 1'b0;
            frame_done_q   <= 1'b0;
            active_scene_q <= '0;
            pending_q      <= 1'b0;
            sub_x_q        <= '0;
            sub_y_q        <= '0;
            src_x_q        <= '0;
            src_y_q        <= '0;
            row_base_q     <= '0;
        end else begin
            state_q        <= state_d;
            rom_en_q       <= rom_en_d;
            rom_addr_q     <= rom_addr_d;
            pix_data_q     <= pix_data_d;
            pix_valid_q    <= pix_valid_d;
            frame_busy_q   <= frame_busy_d;
            frame_done_q   <= frame_done_d;
            active_scene_q <= active_scene_d;
            pending_q      <= pending_d;
            sub_x_q        <= sub_x_d;
            sub_y_q        <= sub_y_d;
            src_x_q        <= src_x_d;
            src_y_q        <= src_y_d;
            row_base_q     <= row_base_d;
        end
    end

    assign rom_en       = rom_en_q;
    assign rom_addr     = rom_addr_q;
    assign pix_data     = pix_data_q;
    assign pix_valid    = pix_valid_q;
    assign frame_busy   = frame_busy_q;
    assign frame_done   = frame_done_q;
    assign active_scene = active_scene_q;

endmodule

// File: tb/tb_frame_scan_scheduler.sv
// Bench for frame_scan_scheduler using a reduced 8x6 source so full frames
// stay short. Expected ROM addresses and pixels are queued when a frame is
// requested and compared as the DUT issues reads and transfers.
module tb_frame_scan_scheduler;

    localparam int unsigned SW = 8;
    localparam int unsigned SH = 6;
    localparam int unsigned SC = 3;
    localparam int unsigned PW = 16;
    localparam int unsigned NS = 5;
    localparam int unsigned AW = 9;
    localparam logic [PW-1:0] FILL = 16'h001F;
    localparam int unsigned BUDGET = 6000;

    logic          clk_out = 1'b0;
    logic          rst = 1'b0;
    logic [2:0]    scene_sel = 3'd0;
    logic          frame_req = 1'b0;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [PW-1:0] rom_data = '0;
    logic [PW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic          frame_busy;
    logic          frame_done;
    logic [2:0]    active_scene;

    int errors = 0;
    int checks = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    int exp_frames = 0;
    int ready_mode = 0;

    logic [PW-1:0] pix_q[$];
    logic [AW-1:0] addr_q[$];

    frame_scan_scheduler #(
        .SRC_W(SW), .SRC_H(SH), .SCALE(SC), .PIXEL_SIZE(PW),
        .NUM_SCENES(NS), .ADDR_W(AW), .FILL_COLOR(FILL)
    ) dut (
        .clk_out(clk_out), .rst(rst), .scene_sel(scene_sel), .frame_req(frame_req),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_busy(frame_busy), .frame_done(frame_done), .active_scene(active_scene)
    );

    initial forever #5 clk_out = ~clk_out;

    function automatic logic [PW-1:0] rom_fn(input logic [AW-1:0] a);
        return PW'(32'(a) * 37 + 32'h1234);
    endfunction

    // Synchronous ROM with one cycle of read latency
    always @(posedge clk_out) begin
        if (rom_en) rom_data <= rom_fn(rom_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int s);
        int base;
        base = s * SW * SH;
        exp_frames++;
        if (s < NS) begin
            for (int sy = 0; sy < SH; sy++)
                for (int uy = 0; uy < SC; uy++)
                    for (int sx = 0; sx < SW; sx++)
                        addr_q.push_back(AW'(base + sy * SW + sx));
        end
        for (int y = 0; y < SH * SC; y++)
            for (int x = 0; x < SW * SC; x++)
                pix_q.push_back((s < NS) ? rom_fn(AW'(base + (y / SC) * SW + x / SC)) : FILL);
    endtask

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    task automatic pulse_req();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
    endtask

    task automatic wait_xfer(input int target);
        int n;
        n = 0;
        while (xfer_cnt < target && n < BUDGET) begin
            tick();
            n++;
        end
        chk("xfer_wait_timeout", 32'(n < BUDGET), 1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((pix_q.size() != 0 || frame_busy) && n < BUDGET) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < BUDGET), 1);
        repeat (3) tick();
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_frames));
        chk({tag, "_busy_low"}, 32'(frame_busy), 0);
        chk({tag, "_reads_left"}, 32'(addr_q.size()), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rom_en"}, 32'(rom_en), 0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
        chk({tag, "_pix_data"}, 32'(pix_data), 0);
        chk({tag, "_busy"}, 32'(frame_busy), 0);
        chk({tag, "_done"}, 32'(frame_done), 0);
        chk({tag, "_scene"}, 32'(active_scene), 0);
    endtask

    // Ready generator: 0 = always ready, 1 = random, 2 = stalled
    initial forever begin
        @(posedge clk_out);
        #1;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ($urandom_range(0, 3) != 0);
            default: pix_ready = 1'b0;
        endcase
    end

    // Scoreboard monitor, sampled away from the active edge
    always @(negedge clk_out) begin
        if (rst) begin
            if (rom_en) begin
                chk("rom_read_expected", 32'(addr_q.size() != 0), 1);
                if (addr_q.size() != 0) chk("rom_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
            end
            if (pix_valid) begin
                chk("pix_expected", 32'(pix_q.size() != 0), 1);
                if (pix_q.size() != 0) begin
                    if (pix_ready) begin
                        chk("pix_data", 32'(pix_data), 32'(pix_q.pop_front()));
                        xfer_cnt++;
                    end else begin
                        chk("pix_hold", 32'(pix_data), 32'(pix_q[0]));
                    end
                end
            end
            if (frame_done) done_cnt++;
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        @(negedge clk_out);
        chk_reset("rst");
        tick();
        rst = 1'b1;
        repeat (2) tick();
        chk("idle_no_start", 32'(frame_busy), 0);

        // Scene 0 with a 5-cycle stall mid-row
        push_frame(0);
        pulse_req();
        wait_xfer(40);
        ready_mode = 2;
        repeat (5) tick();
        ready_mode = 0;
        wait_done("f0");
        chk("f0_scene", 32'(active_scene), 0);

        // Scene 2 full frame, always ready
        push_frame(2);
        scene_sel = 3'd2;
        pulse_req();
        wait_done("f2");
        chk("f2_scene", 32'(active_scene), 2);

        // Out-of-range scene streams fill colour with no ROM reads
        push_frame(6);
        scene_sel = 3'd6;
        tick();
        wait_done("f6");
        chk("f6_scene", 32'(active_scene), 6);

        // Scene 1 -> 3 mid-frame plus extra requests: exactly one follow-up frame
        ready_mode = 1;
        push_frame(1);
        scene_sel = 3'd1;
        tick();
        wait_xfer(xfer_cnt + 100);
        push_frame(3);
        scene_sel = 3'd3;
        pulse_req();
        repeat (7) tick();
        pulse_req();
        wait_done("f13");
        chk("f13_scene", 32'(active_scene), 3);
        ready_mode = 0;

        // Request in the same cycle as frame_done queues one more frame
        push_frame(3);
        pulse_req();
        begin
            int n;
            n = 0;
            while (n < BUDGET) begin
                @(negedge clk_out);
                if (frame_done) break;
                n++;
            end
            chk("done_seen", 32'(n < BUDGET), 1);
        end
        push_frame(3);
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        wait_done("fdr");

        // Reset mid-frame abandons the frame; next frame starts at scene base
        push_frame(3);
        pulse_req();
        wait_xfer(xfer_cnt + 200);
        rst = 1'b0;
        tick();
        pix_q.delete();
        addr_q.delete();
        exp_frames--;
        @(negedge clk_out);
        chk_reset("midrst");
        tick();
        rst = 1'b1;
        push_frame(4);
        scene_sel = 3'd4;
        pulse_req();
        wait_done("f4");
        chk("f4_scene", 32'(active_scene), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_scan_scheduler.md
Name: frame_scan_scheduler

Overview:
Sequences one full-screen frame of pixels from the sprite ROM into the ILI9341 SPI controller's pixel input. Each frame is a nearest-neighbour SCALE x upscale (80x80 source to 240x240 screen) of the image selected by scene_sel. The block generates ROM addresses, absorbs the one-cycle ROM latency and presents pixels over a valid/ready handshake. It latches the scene at frame boundaries and schedules re-draws on request or on a scene change.

Parameters:
SRC_W, 80, source image width in pixels
SRC_H, 80, source image height in pixels
SCALE, 3, integer upscale factor; output frame is (SRC_W*SCALE) x (SRC_H*SCALE)
PIXEL_SIZE, 16, RGB565 pixel width
NUM_SCENES, 5, number of images stored back-to-back in the ROM
ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= NUM_SCENES*SRC_W*SRC_H
FILL_COLOR, 16'h001F, colour streamed for scene_sel >= NUM_SCENES

Ports:
clk_out  in  1  block clock (the divided SPI-domain clock)
rst  in  1  synchronous, active-low reset
scene_sel  in  3  requested image index
frame_req  in  1  single-cycle pulse requesting a redraw of the current scene
rom_en  out  1  ROM read strobe
rom_addr  out  ADDR_W  ROM read address
rom_data  in  PIXEL_SIZE  ROM data; valid on the cycle after rom_en
pix_data  out  PIXEL_SIZE  pixel presented to the controller
pix_valid  out  1  pix_data is valid
pix_ready  in  1  controller accepts pix_data this cycle
frame_busy  out  1  high from frame start until frame_done
frame_done  out  1  one-cycle pulse after the last pixel is transferred
active_scene  out  3  scene latched for the current or last frame

Behaviour:
- Reset (rst==0 at a clk_out edge): state=IDLE. rom_en=0, rom_addr=0, pix_data=0, pix_valid=0, frame_busy=0, frame_done=0, active_scene=0, pending=0, all counters=0. Reset wins over every other event, including mid-frame; a partial frame is abandoned and not resumed.
- Transfer rule: a pixel transfers when pix_valid && pix_ready. While pix_valid=1 and pix_ready=0, pix_data is held stable.
- Counters: sub_x, sub_y in 0..SCALE-1; src_x in 0..SRC_W-1; src_y in 0..SRC_H-1. All advance only on a transfer.
  - sub_x increments first. At wrap it clears and src_x increments.
  - At the src_x wrap, sub_y increments.
  - At the sub_y wrap, src_y increments.
- Address: rom_addr = scene_base + src_y*SRC_W + src_x, where scene_base = active_scene*SRC_W*SRC_H. Compute incrementally (row_base register plus src_x); no general multiplier on the per-pixel path. Truncate to ADDR_W.
- States:
  - IDLE: frame_busy=0. Start when frame_req==1 or pending==1 or scene_sel!=active_scene. On start: latch active_scene<=scene_sel, clear counters and pending, set frame_busy=1, go to FETCH.
  - FETCH: drive rom_en=1 and rom_addr for the current src_x/src_y, then go to WAIT. If the latched scene is >= NUM_SCENES, rom_en stays 0 and the state goes directly to PRESENT with pix_data=FILL_COLOR.
  - WAIT: on the next edge, pix_data<=rom_data, pix_valid<=1, go to PRESENT.
  - PRESENT: wait for a transfer.
    - Transfer of the last pixel (src_x=SRC_W-1, src_y=SRC_H-1, sub_x=sub_y=SCALE-1): pix_valid<=0, go to DONE.
    - Transfer with sub_x!=SCALE-1: the same source pixel repeats. pix_valid stays 1 and pix_data is unchanged, giving back-to-back transfers with no ROM access.
    - Otherwise: pix_valid<=0, go to FETCH.
  - DONE: frame_done=1 for exactly one cycle, frame_busy<=0, go to IDLE.
- Mid-frame requests: frame_req or a scene_sel change during frame_busy sets pending=1. The frame in progress finishes with its latched scene, and the next frame starts from IDLE the cycle after DONE. Multiple requests collapse into one pending redraw.
- A frame_req in the same cycle as frame_done sets pending.
- Each frame performs exactly SRC_W*SCALE*SRC_H*SCALE transfers (57600 at the defaults) and exactly SRC_W*SRC_H*SCALE ROM reads (19200; each source row is re-read SCALE times).

Test Plan:
- Reset then frame_req, scene_sel=0, pix_ready=1 -> first rom_addr=0; transfers 0..2 carry ROM[0]; 4th transfer uses rom_addr=1; 241st transfer (row 1) uses rom_addr=0; 721st transfer (row 3) uses rom_addr=80.
- Full frame, scene_sel=2, ready always 1 -> 57600 transfers, last rom_addr=12800+6399=19199, one frame_done pulse, frame_busy low afterwards.
- pix_ready held low 5 cycles mid-row -> pix_valid=1, pix_data and counters unchanged; resumes with no pixel lost or duplicated.
- scene_sel=6 -> rom_en never asserted; every transfer is 16'h001F; active_scene=6.
- scene_sel 1->3 at transfer 1000 -> frame finishes with scene 1 addresses; second frame starts automatically after frame_done with active_scene=3.
- rst low at transfer 30000 -> next cycle all outputs are at reset values and state is IDLE; a subsequent frame_req restarts at rom_addr=scene_base.
